// File: rtl/pipe_hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: instruction codes, the
// "no register" ID, one-hot status codes and the hazard FSM state type.
package pipe_hazard_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register ID meaning "no register"
    localparam logic [3:0] RNONE   = 4'hF;

    // One-hot status codes
    localparam logic [3:0] SAOK    = 4'b1000;
    localparam logic [3:0] SHLT    = 4'b0100;
    localparam logic [3:0] SADR    = 4'b0010;
    localparam logic [3:0] SINS    = 4'b0001;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_WAIT = 2'd1,
        HALTED  = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_unit_sat_counter.sv
// Saturating event counter.
// Ports: clk, rst (async, active-high), inc (count this cycle),
//        clr (synchronous zero, wins over inc), cnt (current value).
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard/control unit. Detects exceptions, branch mispredicts,
// load-use hazards and returns, and drives the per-stage stall/bubble
// controls. A small FSM stretches load-use stalls to LU_PENALTY cycles and
// latches the halted condition until reset. Three saturating counters
// track stall, bubble and mispredict cycles.
// Inputs : clk, rst, stage icodes (D/E/M), decode sources, E-stage load
//          destination, branch condition, M/W status, counter clear.
// Outputs: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
//          set_cc, halted, cnt_stall, cnt_bubble, cnt_mispred.
module pipe_hazard_unit
    import pipe_hazard_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int ICODE_W    = 4,
    parameter int STAT_W     = 4,
    parameter int LU_PENALTY = 1,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic               e_cnd,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  W_stat,
    input  logic               clr_cnt,
    output logic               F_stall,
    output logic               D_stall,
    output logic               D_bubble,
    output logic               E_bubble,
    output logic               M_bubble,
    output logic               W_stall,
    output logic               set_cc,
    output logic               halted,
    output logic [CNT_W-1:0]   cnt_stall,
    output logic [CNT_W-1:0]   cnt_bubble,
    output logic [CNT_W-1:0]   cnt_mispred
);

    localparam int LU_W = 4;

    hz_state_e       state_q, state_d;
    logic [LU_W-1:0] lu_cnt_q, lu_cnt_d;

    logic m_bad, w_bad, exc, mispred, load_use, ret_hit, mp_evt;

    assign m_bad    = (m_stat != STAT_W'(SAOK));
    assign w_bad    = (W_stat != STAT_W'(SAOK));
    assign exc      = m_bad | w_bad;
    assign mispred  = (E_icode == ICODE_W'(IJXX)) && !e_cnd;
    assign load_use = ((E_icode == ICODE_W'(IMRMOVQ)) || (E_icode == ICODE_W'(IPOPQ))) &&
                      (E_dstM != REG_W'(RNONE)) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_hit  = (D_icode == ICODE_W'(IRET)) || (E_icode == ICODE_W'(IRET)) ||
                      (M_icode == ICODE_W'(IRET));

    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        halted   = 1'b0;
        mp_evt   = 1'b0;
        // Outputs are combinational, so they are gated here to read 0 the
        // moment rst rises rather than after the flops settle.
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (exc) begin
                        M_bubble = m_bad;
                        W_stall  = w_bad;
                        if (w_bad) state_d = HALTED;
                    end else if (mispred) begin
                        D_bubble = 1'b1;
                        E_bubble = 1'b1;
                        mp_evt   = 1'b1;
                    end else if (load_use) begin
                        F_stall  = 1'b1;
                        D_stall  = 1'b1;
                        E_bubble = 1'b1;
                        if (LU_PENALTY > 1) begin
                            state_d  = LU_WAIT;
                            lu_cnt_d = LU_W'(LU_PENALTY - 1);
                        end
                    end else if (ret_hit) begin
                        F_stall  = 1'b1;
                        D_bubble = 1'b1;
                    end
                end
                LU_WAIT: begin
                    if (exc) begin
                        // Exception overrides the pending stall entirely.
                        M_bubble = m_bad;
                        W_stall  = w_bad;
                        state_d  = w_bad ? HALTED : RUN;
                        lu_cnt_d = '0;
                    end else begin
                        F_stall  = 1'b1;
                        D_stall  = 1'b1;
                        E_bubble = 1'b1;
                        lu_cnt_d = lu_cnt_q - 1'b1;
                        // Leaving on the count-to-zero edge makes the total
                        // stall exactly LU_PENALTY cycles (1 in RUN + rest here).
                        if (lu_cnt_q <= LU_W'(1)) state_d = RUN;
                    end
                end
                HALTED: begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    M_bubble = 1'b1;
                    W_stall  = 1'b1;
                    halted   = 1'b1;
                end
                default: begin
                    state_d  = RUN;
                    lu_cnt_d = '0;
                end
            endcase
        end
    end

    assign set_cc = !rst && !((E_icode == ICODE_W'(IHALT)) || exc || (state_q == HALTED));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            lu_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk(clk), .rst(rst), .inc(F_stall), .clr(clr_cnt), .cnt(cnt_stall)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_bubble (
        .clk(clk), .rst(rst), .inc(D_bubble | E_bubble | M_bubble), .clr(clr_cnt),
        .cnt(cnt_bubble)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_mispred (
        .clk(clk), .rst(rst), .inc(mp_evt), .clr(clr_cnt), .cnt(cnt_mispred)
    );

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter REG_W, default 4: register-ID width.
REQ-002 SHALL have parameter ICODE_W, default 4: instruction-code width.
REQ-003 SHALL have parameter STAT_W, default 4: one-hot status width.
REQ-004 SHALL have parameter LU_PENALTY, default 1, legal 1..15: load-use stall cycles.
REQ-005 SHALL have parameter CNT_W, default 32: performance-counter width.
REQ-006 Clocking and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
REQ-007 Ports, in order:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- D_icode, E_icode, M_icode  in  ICODE_W  icode of the D, E and M stages
- d_srcA, d_srcB  in  REG_W  decode source registers
- E_dstM  in  REG_W  E-stage load destination
- e_cnd  in  1  E-stage condition result
- m_stat, W_stat  in  STAT_W  M and W stage status
- clr_cnt  in  1  synchronous clear of the counters
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1  pipeline control
- set_cc  out  1  condition-code write enable
- halted  out  1  machine halted
- cnt_stall, cnt_bubble, cnt_mispred  out  CNT_W  performance counters

Function
REQ-008 Mispredict SHALL be detected when E_icode==IJXX and e_cnd==0.
REQ-009 Load-use SHALL be detected when all of the following hold: E_icode is IMRMOVQ or IPOPQ; E_dstM!=RNONE; E_dstM equals d_srcA or d_srcB.
REQ-010 Return SHALL be detected when any of D_icode, E_icode or M_icode equals IRET.
REQ-011 Exception SHALL be detected when m_stat!=SAOK or W_stat!=SAOK.
REQ-012 The FSM SHALL have three states: RUN, LU_WAIT and HALTED.
REQ-013 In RUN, the conditions SHALL be evaluated in this priority order: exception, mispredict, load-use, return.
REQ-014 Exception in RUN: M_bubble=1 when m_stat!=SAOK; W_stall=1 when W_stat!=SAOK; when W_stat!=SAOK the next state SHALL be HALTED.
REQ-015 Mispredict in RUN: D_bubble=1 and E_bubble=1.
REQ-016 Load-use in RUN: F_stall=1, D_stall=1, E_bubble=1; when LU_PENALTY>1, the next state SHALL be LU_WAIT with a down-counter loaded with LU_PENALTY-1.
REQ-017 LU_WAIT: F_stall, D_stall and E_bubble SHALL be 1; the counter decrements each cycle; the state returns to RUN on the cycle the counter reaches 0. Total stall = exactly LU_PENALTY cycles.
REQ-018 Exception during LU_WAIT SHALL override it: REQ-014 outputs apply and the counter is abandoned.
REQ-019 Return in RUN: F_stall=1 and D_bubble=1.
REQ-020 HALTED: F_stall=1, D_stall=1, M_bubble=1, W_stall=1, halted=1; the state SHALL be left only by rst.
REQ-021 With no condition active in RUN, all six control outputs SHALL be 0.
REQ-022 set_cc SHALL be 0 whenever E_icode==IHALT, or an exception is detected, or the state is HALTED, independent of the other conditions; otherwise set_cc=1.
REQ-023 All control outputs SHALL be combinational from the state and the current inputs; the state and counters SHALL be registered on the rising edge of clk.
REQ-024 Counter updates:
- cnt_stall increments on any cycle with F_stall=1.
- cnt_bubble increments on any cycle with D_bubble or E_bubble or M_bubble equal to 1.
- cnt_mispred increments once per mispredict cycle.
- All three saturate at 2^CNT_W-1.
- clr_cnt zeroes all three and takes precedence over increment in the same cycle.

Reset
REQ-025 rst SHALL force, immediately: state RUN, LU counter 0, all counters 0, all control outputs 0, set_cc=0, halted=0.
REQ-026 rst asserted mid-LU_WAIT or in HALTED SHALL abandon that state with no residual stall after rst deasserts.

Structure
REQ-027 The shared package SHALL hold:
- icode constants IHALT=0, IJXX=7, IMRMOVQ=5, IRET=9, IPOPQ=B;
- RNONE=F;
- status codes SAOK=1000, SHLT, SADR, SINS;
- the FSM state enum.
REQ-028 One sub-module, sat_counter (CNT_W-wide, with inc, clr and saturation), SHALL be instantiated three times.

Verification
REQ-029 E_icode=IJXX, e_cnd=0, D_icode=IRET -> D_bubble=1, E_bubble=1, F_stall=0, cnt_mispred +1.
REQ-030 LU_PENALTY=3, E_icode=IMRMOVQ, E_dstM=2, d_srcA=2 for one cycle -> F_stall=D_stall=E_bubble=1 for exactly 3 cycles, then all 0; cnt_stall=3.
REQ-031 E_icode=IPOPQ, E_dstM=RNONE, d_srcB=F -> no stall; set_cc=1.
REQ-032 W_stat=SHLT during LU_WAIT -> W_stall=1, set_cc=0 that cycle; next cycle halted=1 and all halt outputs held for 100 cycles; rst then gives all outputs 0.
REQ-033 cnt_stall preloaded to all-ones via a forced stall run -> stays saturated; clr_cnt with a stall in the same cycle -> counter reads 0.
REQ-034 M_icode=IRET with E_icode=IHALT -> F_stall=1, D_bubble=1, set_cc=0.
